instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the control decoder. Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. Presents each word on `instr`, which feeds the decoder's `rawData` input. Inserts NOP bubbles (all-zero words, decoded as NOP) whenever no valid instruction is held. Supports PC redirect for future jump/branch logic.

---
 rtl/instr_fetch_if.sv | 13 +
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Single-cycle req/ack handshake; read data is valid in the ack cycle.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory handshake, NOP bubbles and PC redirect.
// Optional fetch timeout with sticky error is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    instr_fetch_if.master     mem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t            state;
    logic              req_q;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              lock;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("instr_fetch: TIMEOUT must be at least 1");
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = pc;

    // A redirect arriving in the ack cycle itself takes effect immediately.
    always_comb begin
        redirect    = pend | pc_load;
        redirect_pc = pc_load ? pc_load_val : pend_pc;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign fetch_err = err_q;
    assign lock      = err_q;
`else
    assign fetch_err = 1'b0;
    assign lock      = 1'b0;
`endif

    // NOTE: all state is assigned with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_load) pc <= pc_load_val;
                    if (en && !lock) begin
                        state <= FETCH;
                        req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end

                FETCH: begin
                    if (mem.mem_ack) begin
                        if (redirect) begin
                            pc    <= redirect_pc;
                            pend  <= 1'b0;
                            state <= en ? FETCH : IDLE;
                            req_q <= en;
`ifdef FETCH_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            instr       <= mem.mem_rdata;
                            instr_valid <= 1'b1;
                            pc          <= pc + 1'b1;
                            state       <= HOLD;
                            req_q       <= 1'b0;
                        end
                    end else begin
                        if (pc_load) begin
                            pend    <= 1'b1;
                            pend_pc <= pc_load_val;
                        end
`ifdef FETCH_TIMEOUT_EN
                        // Give up after TIMEOUT request cycles; only rst leaves the lock.
                        if (cnt == CNT_LAST) begin
                            err_q <= 1'b1;
                            state <= IDLE;
                            req_q <= 1'b0;
                            pend  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end

                HOLD: begin
                    if (pc_load || !stall) begin
                        if (pc_load) pc <= pc_load_val;
                        instr       <= '0;
                        instr_valid <= 1'b0;
                        state       <= en ? FETCH : IDLE;
                        req_q       <= en;
`ifdef FETCH_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset/timeout sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_instr_fetch;

    localparam int TO = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, stall, pc_load;
    logic [7:0]  pc_load_val;
    logic [31:0] instr;
    logic        instr_valid, fetch_err;
    logic [7:0]  pc;

    int total = 0;
    int bad   = 0;

    instr_fetch_if #(.ADDR_W(8)) bus ();

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'd0), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .stall      (stall),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .mem        (bus.master),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          en, st, ld;
        logic [7:0]  lv;
        bit          ack;
        logic [31:0] rd;
        bit          x_req, x_valid;
        logic [31:0] x_instr;
        logic [7:0]  x_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit e, bit s, bit l, logic [7:0] lv, bit a, logic [31:0] rd,
                                bit xr, bit xv, logic [31:0] xi, logic [7:0] xp);
        vec_t v;
        v.en = e; v.st = s; v.ld = l; v.lv = lv; v.ack = a; v.rd = rd;
        v.x_req = xr; v.x_valid = xv; v.x_instr = xi; v.x_pc = xp;
        return v;
    endfunction

    task automatic drive(bit r, bit e, bit s, bit l, logic [7:0] lv, bit a, logic [31:0] rd);
        rst = r; en = e; stall = s; pc_load = l; pc_load_val = lv;
        bus.mem_ack = a; bus.mem_rdata = rd;
    endtask

    // Behavioural model: phase of the fetch stage plus the architectural registers.
    typedef enum {S_IDLE, S_FETCH, S_HOLD} mphase_t;
    mphase_t     m_ph;
    logic [7:0]  m_pc, m_tgt;
    logic [31:0] m_instr;
    bit          m_valid, m_pend, m_err;
    int          m_cnt;

    task automatic model_step(bit r, bit e, bit s, bit l, logic [7:0] lv, bit a, logic [31:0] rd);
        if (r) begin
            m_ph = S_IDLE; m_pc = 8'd0; m_tgt = 8'd0; m_instr = '0;
            m_valid = 0; m_pend = 0; m_err = 0; m_cnt = 0;
            return;
        end
        case (m_ph)
            S_IDLE: begin
                if (l) m_pc = lv;
                if (e && !m_err) begin m_ph = S_FETCH; m_cnt = 0; end
            end
            S_FETCH: begin
                if (a) begin
                    if (m_pend || l) begin
                        m_pc = l ? lv : m_tgt;
                        m_pend = 0;
                        m_ph = e ? S_FETCH : S_IDLE;
                        m_cnt = 0;
                    end else begin
                        m_instr = rd; m_valid = 1; m_pc = m_pc + 8'd1; m_ph = S_HOLD;
                    end
                end else begin
                    if (l) begin m_pend = 1; m_tgt = lv; end
                    if (TO_ON) begin
                        m_cnt++;
                        if (m_cnt == TO) begin m_err = 1; m_ph = S_IDLE; m_pend = 0; end
                    end
                end
            end
            default: begin
                if (l || !s) begin
                    if (l) m_pc = lv;
                    m_valid = 0; m_instr = '0;
                    m_ph = e ? S_FETCH : S_IDLE;
                    m_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic cmp_model(string tag);
        check({tag, ".mem_req"},     bus.mem_req, 32'(m_ph == S_FETCH));
        check({tag, ".mem_addr"},    bus.mem_addr, m_pc);
        check({tag, ".pc"},          pc, m_pc);
        check({tag, ".instr"},       instr, m_instr);
        check({tag, ".instr_valid"}, instr_valid, m_valid);
        check({tag, ".fetch_err"},   fetch_err, m_err);
    endtask

    logic [31:0] rom [256];

    initial begin
        drive(1, 0, 0, 0, 8'd0, 0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset.mem_req", bus.mem_req, 0);
        check("reset.instr", instr, 0);
        check("reset.instr_valid", instr_valid, 0);
        check("reset.pc", pc, 0);
        check("reset.fetch_err", fetch_err, 0);

        // Directed table: inputs for one cycle, expected outputs after that edge.
        vecs.push_back(mk(1,0,0,8'h00,0,32'h0,        1,0,32'h0,8'h00));
        vecs.push_back(mk(1,0,0,8'h00,1,32'h18221820, 0,1,32'h18221820,8'h01));
        vecs.push_back(mk(1,1,0,8'h00,0,32'h0,        0,1,32'h18221820,8'h01));
        vecs.push_back(mk(1,1,0,8'h00,0,32'h0,        0,1,32'h18221820,8'h01));
        vecs.push_back(mk(1,1,0,8'h00,0,32'h0,        0,1,32'h18221820,8'h01));
        vecs.push_back(mk(1,0,0,8'h00,0,32'h0,        1,0,32'h0,8'h01));
        vecs.push_back(mk(1,0,0,8'h00,1,32'hAABBCCDD, 0,1,32'hAABBCCDD,8'h02));
        vecs.push_back(mk(0,0,0,8'h00,0,32'h0,        0,0,32'h0,8'h02));
        vecs.push_back(mk(0,0,1,8'hFF,0,32'h0,        0,0,32'h0,8'hFF));
        vecs.push_back(mk(1,0,0,8'h00,0,32'h0,        1,0,32'h0,8'hFF));
        vecs.push_back(mk(1,0,0,8'h00,1,32'h11111111, 0,1,32'h11111111,8'h00));
        vecs.push_back(mk(1,0,0,8'h00,0,32'h0,        1,0,32'h0,8'h00));
        vecs.push_back(mk(1,0,1,8'h40,0,32'h0,        1,0,32'h0,8'h00));
        vecs.push_back(mk(1,0,0,8'h00,0,32'h0,        1,0,32'h0,8'h00));
        vecs.push_back(mk(1,0,0,8'h00,1,32'hDEADBEEF, 1,0,32'h0,8'h40));
        vecs.push_back(mk(1,0,0,8'h00,1,32'h12345678, 0,1,32'h12345678,8'h41));
        vecs.push_back(mk(1,1,1,8'h10,0,32'h0,        1,0,32'h0,8'h10));
        vecs.push_back(mk(0,0,0,8'h00,0,32'h0,        1,0,32'h0,8'h10));
        vecs.push_back(mk(0,0,0,8'h00,1,32'hCAFEF00D, 0,1,32'hCAFEF00D,8'h11));
        vecs.push_back(mk(0,0,0,8'h00,0,32'h0,        0,0,32'h0,8'h11));

        foreach (vecs[i]) begin
            drive(0, vecs[i].en, vecs[i].st, vecs[i].ld, vecs[i].lv, vecs[i].ack, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d.mem_req", i), bus.mem_req, vecs[i].x_req);
            check($sformatf("vec%0d.instr_valid", i), instr_valid, vecs[i].x_valid);
            check($sformatf("vec%0d.instr", i), instr, vecs[i].x_instr);
            check($sformatf("vec%0d.pc", i), pc, vecs[i].x_pc);
            check($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vecs[i].x_pc);
            check($sformatf("vec%0d.fetch_err", i), fetch_err, 0);
        end

        // Reset while a request is outstanding and acked in the same cycle.
        drive(0, 1, 0, 0, 8'h00, 0, 32'h0);
        @(negedge clk);
        check("rstfetch.pre_req", bus.mem_req, 1);
        drive(1, 1, 0, 1, 8'h55, 1, 32'h87654321);
        @(negedge clk);
        check("rstfetch.mem_req", bus.mem_req, 0);
        check("rstfetch.instr", instr, 0);
        check("rstfetch.instr_valid", instr_valid, 0);
        check("rstfetch.pc", pc, 0);
        drive(0, 0, 0, 0, 8'h00, 1, 32'h87654321);
        @(negedge clk);
        check("rstfetch.after_req", bus.mem_req, 0);
        check("rstfetch.after_valid", instr_valid, 0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n_req = 0;
            drive(1, 0, 0, 0, 8'h00, 0, 32'h0);
            @(negedge clk);
            drive(0, 1, 0, 0, 8'h00, 0, 32'h0);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.mem_req) n_req++;
            end
            check("timeout.req_cycles", n_req, TO);
            check("timeout.fetch_err", fetch_err, 1);
            check("timeout.locked_req", bus.mem_req, 0);
            check("timeout.pc", pc, 0);
            drive(1, 1, 0, 0, 8'h00, 0, 32'h0);
            @(negedge clk);
            check("timeout.rst_clears", fetch_err, 0);
            // Ack landing on the last allowed request cycle still counts.
            drive(0, 1, 0, 0, 8'h00, 0, 32'h0);
            @(negedge clk);
            for (int c = 1; c < TO; c++) @(negedge clk);
            check("timeout.edge_req", bus.mem_req, 1);
            drive(0, 1, 0, 0, 8'h00, 1, 32'h0BADF00D);
            @(negedge clk);
            check("timeout.edge_valid", instr_valid, 1);
            check("timeout.edge_instr", instr, 32'h0BADF00D);
            check("timeout.edge_err", fetch_err, 0);
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        drive(1, 0, 0, 0, 8'h00, 0, 32'h0);
        model_step(1, 0, 0, 0, 8'h00, 0, 32'h0);
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r, e, s, l, a;
            logic [7:0]  lv;
            cmp_model($sformatf("rand%0d", cyc));
            r  = ($urandom % 150) == 0;
            e  = ($urandom % 4) != 0;
            s  = ($urandom % 3) == 0;
            l  = ($urandom % 10) == 0;
            lv = 8'($urandom);
            a  = (m_ph == S_FETCH) && (($urandom % 3) == 0);
            drive(r, e, s, l, lv, a, rom[m_pc]);
            model_step(r, e, s, l, lv, a, rom[m_pc]);
            @(negedge clk);
        end
        cmp_model("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
